// File: rtl/mlsu_maddr_gen.sv
// -----------------------------------------------------------------------------
// mlsu_maddr_gen
//
// Matrix-register-file address sequencer for the MLSU. Accepts one transfer
// descriptor (target mreg, layout mode, beat count) and streams one
// {set, bank} MRF address per beat under valid/ready flow control. Supports
// row-major, column-major and the two bank-skewed orders (TRANSPOSE walks
// column-major, RESHAPE walks row-major, both rotate the bank by the local
// set index so consecutive beats spread over different banks).
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   flush_i       synchronous abort of the current descriptor
//   req_valid_i   descriptor valid
//   req_ready_o   descriptor accepted on valid & ready
//   req_mreg_i    target mreg index
//   req_mode_i    layout mode (ROW_MAJOR, COL_MAJOR, TRANSPOSE, RESHAPE)
//   req_len_i     beat count; 0 or larger than a full mreg means full mreg
//   addr_valid_o  address beat valid
//   addr_ready_i  consumer accepts the beat
//   addr_set_o    global MRF set = mreg * NrSetPerMreg + local set
//   addr_bank_o   bank index
//   addr_last_o   final beat of the descriptor
//   busy_o        descriptor in progress
// -----------------------------------------------------------------------------
module mlsu_maddr_gen #(
   parameter int unsigned NrMregs      = 16,
   parameter int unsigned NrSetPerMreg = 4,
   parameter int unsigned NrBanks      = 8,
   localparam int unsigned MregBits    = $clog2(NrMregs),
   localparam int unsigned SetLBits    = $clog2(NrSetPerMreg),
   localparam int unsigned SetBits     = $clog2(NrMregs * NrSetPerMreg),
   localparam int unsigned BankBits    = $clog2(NrBanks),
   localparam int unsigned LenBits     = $clog2(NrSetPerMreg * NrBanks) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [MregBits-1:0] req_mreg_i,
   input  logic [1:0]          req_mode_i,
   input  logic [LenBits-1:0]  req_len_i,
   output logic                addr_valid_o,
   input  logic                addr_ready_i,
   output logic [SetBits-1:0]  addr_set_o,
   output logic [BankBits-1:0] addr_bank_o,
   output logic                addr_last_o,
   output logic                busy_o
);

   typedef enum logic [1:0] {
      ROW_MAJOR = 2'd0,
      COL_MAJOR = 2'd1,
      TRANSPOSE = 2'd2,
      RESHAPE   = 2'd3
   } m_mop_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [LenBits-1:0] FullLen = LenBits'(NrSetPerMreg * NrBanks);

   state_e                state_q;
   logic [MregBits-1:0]   mreg_q;
   m_mop_e                mode_q;
   logic [LenBits-1:0]    len_q;
   logic [LenBits-1:0]    cnt_q;

   logic                  run;
   logic                  last_beat;
   logic                  accept;
   logic                  beat_done;
   logic [LenBits-1:0]    len_clamped;
   logic [SetLBits-1:0]   set_l;
   logic [BankBits-1:0]   col;
   logic [BankBits-1:0]   bank;

   assign run       = (state_q == RUN);
   assign last_beat = run && (cnt_q == (len_q - LenBits'(1)));

   // In RUN a new descriptor can only slip in on the final handshake, which
   // is what gives zero-bubble back-to-back streams.
   assign req_ready_o = ~flush_i & (run ? (last_beat & addr_ready_i) : 1'b1);
   assign accept      = req_valid_i & req_ready_o;
   assign beat_done   = run & addr_ready_i;

   assign len_clamped = ((req_len_i == '0) || (req_len_i > FullLen)) ? FullLen : req_len_i;

   // Traversal order: row-major splits c as {set_l, col}, column-major as
   // {col, set_l}. Skewed modes rotate the bank by the local set.
   always_comb begin
      set_l = '0;
      col   = '0;
      case (mode_q)
         ROW_MAJOR, RESHAPE: begin
            set_l = cnt_q[BankBits +: SetLBits];
            col   = cnt_q[BankBits-1:0];
         end
         default: begin
            set_l = cnt_q[SetLBits-1:0];
            col   = cnt_q[SetLBits +: BankBits];
         end
      endcase
      if (mode_q == TRANSPOSE || mode_q == RESHAPE) begin
         bank = col + BankBits'(set_l);
      end else begin
         bank = col;
      end
   end

   assign addr_valid_o = run;
   assign addr_last_o  = last_beat;
   assign addr_set_o   = run ? {mreg_q, set_l} : '0;
   assign addr_bank_o  = run ? bank : '0;
   assign busy_o       = run;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         mreg_q  <= '0;
         mode_q  <= ROW_MAJOR;
         len_q   <= '0;
         cnt_q   <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (accept) begin
         state_q <= RUN;
         mreg_q  <= req_mreg_i;
         mode_q  <= m_mop_e'(req_mode_i);
         len_q   <= len_clamped;
         cnt_q   <= '0;
      end else if (beat_done) begin
         if (last_beat) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            cnt_q   <= cnt_q + LenBits'(1);
         end
      end
   end

endmodule

// File: tb/tb_mlsu_maddr_gen.sv
// -----------------------------------------------------------------------------
// tb_mlsu_maddr_gen
//
// Directed bench for mlsu_maddr_gen with default parameters (16 mregs,
// 4 sets per mreg, 8 banks). Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mlsu_maddr_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_mreg;
   logic [1:0] req_mode;
   logic [5:0] req_len;
   logic       addr_valid;
   logic       addr_ready;
   logic [5:0] addr_set;
   logic [2:0] addr_bank;
   logic       addr_last;
   logic       busy;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   mlsu_maddr_gen #(
      .NrMregs      (16),
      .NrSetPerMreg (4),
      .NrBanks      (8)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (flush),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_mreg_i   (req_mreg),
      .req_mode_i   (req_mode),
      .req_len_i    (req_len),
      .addr_valid_o (addr_valid),
      .addr_ready_i (addr_ready),
      .addr_set_o   (addr_set),
      .addr_bank_o  (addr_bank),
      .addr_last_o  (addr_last),
      .busy_o       (busy)
   );

   // Drive a descriptor and return 1 ns after the edge that accepted it.
   task automatic issue(input logic [3:0] m, input logic [1:0] md, input logic [5:0] l);
      int waited = 0;
      req_valid = 1'b1;
      req_mreg  = m;
      req_mode  = md;
      req_len   = l;
      @(negedge clk);
      while (req_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      vec_cnt++;
      if (req_ready !== 1'b1) begin
         err_cnt++;
         $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_mreg = '0;
      req_mode = '0; req_len = '0; addr_ready = 1'b0;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if ({req_ready, addr_valid, addr_set, addr_bank, addr_last, busy} !== {1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_hold: rdy/vld/set/bank/last/busy=%b/%b/%0d/%0d/%b/%b required 1/0/0/0/0/0",
                  req_ready, addr_valid, addr_set, addr_bank, addr_last, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if ({req_ready, addr_valid, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL reset_release: rdy/vld/busy=%b/%b/%b required 1/0/0", req_ready, addr_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_row_major();
      logic [5:0] es [3] = '{6'd8, 6'd8, 6'd8};
      logic [2:0] eb [3] = '{3'd0, 3'd1, 3'd2};
      addr_ready = 1'b1;
      req_valid = 1'b1; req_mreg = 4'd2; req_mode = 2'd0; req_len = 6'd3;
      @(negedge clk);
      vec_cnt++;
      if ({req_ready, addr_valid} !== 2'b10) begin
         err_cnt++;
         $display("FAIL row_pre_accept: rdy/vld=%b/%b required 1/0", req_ready, addr_valid);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, es[k], eb[k], (k == 2)}) begin
            err_cnt++;
            $display("FAIL row_beat%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/%0d/%0d/%b",
                     k, addr_valid, addr_set, addr_bank, addr_last, es[k], eb[k], (k == 2));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      vec_cnt++;
      if ({req_ready, addr_valid, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL row_idle: rdy/vld/busy=%b/%b/%b required 1/0/0", req_ready, addr_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_col_major();
      logic [5:0] es [6] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd4, 6'd5};
      logic [2:0] eb [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
      addr_ready = 1'b1;
      issue(4'd1, 2'd1, 6'd6);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, es[k], eb[k], (k == 5)}) begin
            err_cnt++;
            $display("FAIL col_beat%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/%0d/%0d/%b",
                     k, addr_valid, addr_set, addr_bank, addr_last, es[k], eb[k], (k == 5));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_skewed();
      logic [5:0] ts [5] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
      logic [2:0] tb [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1};
      logic [5:0] rs [10] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1};
      logic [2:0] rb [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
      addr_ready = 1'b1;
      @(posedge clk); #1;
      issue(4'd0, 2'd2, 6'd5);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, ts[k], tb[k], (k == 4)}) begin
            err_cnt++;
            $display("FAIL transpose_beat%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/%0d/%0d/%b",
                     k, addr_valid, addr_set, addr_bank, addr_last, ts[k], tb[k], (k == 4));
         end
         @(posedge clk); #1;
      end
      issue(4'd0, 2'd3, 6'd10);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, rs[k], rb[k], (k == 9)}) begin
            err_cnt++;
            $display("FAIL reshape_beat%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/%0d/%0d/%b",
                     k, addr_valid, addr_set, addr_bank, addr_last, rs[k], rb[k], (k == 9));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      addr_ready = 1'b1;
      @(posedge clk); #1;
      issue(4'd3, 2'd0, 6'd4);
      // beat 0 of A
      @(negedge clk);
      vec_cnt++;
      if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, 6'd12, 3'd0, 1'b0}) begin
         err_cnt++;
         $display("FAIL b2b_a0: vld/set/bank/last=%b/%0d/%0d/%b required 1/12/0/0", addr_valid, addr_set, addr_bank, addr_last);
      end
      @(posedge clk); #1;
      // stall on beat 1 for three cycles
      addr_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last, req_ready, busy} !== {1'b1, 6'd12, 3'd1, 1'b0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL b2b_stall%0d: vld/set/bank/last/rdy/busy=%b/%0d/%0d/%b/%b/%b required 1/12/1/0/0/1",
                     r, addr_valid, addr_set, addr_bank, addr_last, req_ready, busy);
         end
         @(posedge clk); #1;
      end
      addr_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, 6'd12, 3'(k), 1'b0}) begin
            err_cnt++;
            $display("FAIL b2b_a%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/12/%0d/0",
                     k, addr_valid, addr_set, addr_bank, addr_last, k);
         end
         @(posedge clk); #1;
      end
      // descriptor B offered during the last beat of A
      req_valid = 1'b1; req_mreg = 4'd4; req_mode = 2'd1; req_len = 6'd2;
      @(negedge clk);
      vec_cnt++;
      if ({addr_valid, addr_set, addr_bank, addr_last, req_ready} !== {1'b1, 6'd12, 3'd3, 1'b1, 1'b1}) begin
         err_cnt++;
         $display("FAIL b2b_a3: vld/set/bank/last/rdy=%b/%0d/%0d/%b/%b required 1/12/3/1/1",
                  addr_valid, addr_set, addr_bank, addr_last, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, 6'(16 + k), 3'd0, (k == 1)}) begin
            err_cnt++;
            $display("FAIL b2b_b%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/%0d/0/%b",
                     k, addr_valid, addr_set, addr_bank, addr_last, 16 + k, (k == 1));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      vec_cnt++;
      if ({addr_valid, busy} !== 2'b00) begin
         err_cnt++;
         $display("FAIL b2b_idle: vld/busy=%b/%b required 0/0", addr_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_full_len();
      logic [5:0] lens [2] = '{6'd0, 6'd40};
      addr_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         issue(4'd15, 2'd0, lens[t]);
         for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({addr_valid, addr_set, addr_bank, addr_last} !== {1'b1, 6'(60 + k / 8), 3'(k % 8), (k == 31)}) begin
               err_cnt++;
               $display("FAIL full_len%0d_beat%0d: vld/set/bank/last=%b/%0d/%0d/%b required 1/%0d/%0d/%b",
                        lens[t], k, addr_valid, addr_set, addr_bank, addr_last, 60 + k / 8, k % 8, (k == 31));
            end
            @(posedge clk); #1;
         end
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL full_len%0d_end: vld/busy=%b/%b required 0/0", lens[t], addr_valid, busy);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      addr_ready = 1'b1;
      issue(4'd1, 2'd0, 6'd8);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank} !== {1'b1, 6'd4, 3'(k)}) begin
            err_cnt++;
            $display("FAIL flush_beat%0d: vld/set/bank=%b/%0d/%0d required 1/4/%0d", k, addr_valid, addr_set, addr_bank, k);
         end
         @(posedge clk); #1;
      end
      flush = 1'b1;
      req_valid = 1'b1; req_mreg = 4'd5; req_mode = 2'd0; req_len = 6'd2;
      @(negedge clk);
      vec_cnt++;
      if ({req_ready, addr_valid, addr_set, addr_bank} !== {1'b0, 1'b1, 6'd4, 3'd4}) begin
         err_cnt++;
         $display("FAIL flush_cycle: rdy/vld/set/bank=%b/%b/%0d/%0d required 0/1/4/4", req_ready, addr_valid, addr_set, addr_bank);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if ({req_ready, addr_valid, busy} !== 3'b100) begin
         err_cnt++;
         $display("FAIL flush_after: rdy/vld/busy=%b/%b/%b required 1/0/0", req_ready, addr_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      addr_ready = 1'b1;
      issue(4'd2, 2'd1, 6'd8);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vec_cnt++;
         if ({addr_valid, addr_set, addr_bank} !== {1'b1, 6'(8 + k), 3'd0}) begin
            err_cnt++;
            $display("FAIL areset_beat%0d: vld/set/bank=%b/%0d/%0d required 1/%0d/0", k, addr_valid, addr_set, addr_bank, 8 + k);
         end
         @(posedge clk); #1;
      end
      // assert reset between edges; outputs must react before any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({req_ready, addr_valid, addr_set, addr_bank, addr_last, busy} !== {1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL areset_now: rdy/vld/set/bank/last/busy=%b/%b/%0d/%0d/%b/%b required 1/0/0/0/0/0",
                  req_ready, addr_valid, addr_set, addr_bank, addr_last, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if ({addr_valid, busy} !== 2'b00) begin
         err_cnt++;
         $display("FAIL areset_release: vld/busy=%b/%b required 0/0", addr_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_row_major();
      test_col_major();
      test_skewed();
      test_back_to_back();
      test_full_len();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
